// File: rtl/bop_engine.sv
// Best-offset hardware prefetcher: learns a line offset from recent fills
// and issues up to DEGREE same-page prefetches per demand trigger.
module bop_engine #(
    parameter int ADDR_W     = 48,
    parameter int LINE_LOG   = 6,
    parameter int PAGE_LOG   = 12,
    parameter int NOFFSETS   = 16,
    parameter int DEGREE     = 2,
    parameter int RR_ENTRIES = 64,
    parameter int RR_TAG     = 12,
    parameter int SCORE_MAX  = 31,
    parameter int ROUND_MAX  = 100,
    parameter int BAD_SCORE  = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                acc_valid_i,
    input  logic [ADDR_W-LINE_LOG-1:0]          acc_line_i,
    input  logic                                acc_hit_i,
    input  logic                                acc_pf_hit_i,
    input  logic                                fill_valid_i,
    input  logic [ADDR_W-LINE_LOG-1:0]          fill_line_i,
    input  logic                                fill_pf_i,
    output logic                                pf_valid_o,
    input  logic                                pf_ready_i,
    output logic [ADDR_W-LINE_LOG-1:0]          pf_line_o,
    output logic [$clog2(NOFFSETS+1)-1:0]       best_offset_o,
    output logic [$clog2(SCORE_MAX+1)-1:0]      best_score_o,
    output logic                                pf_enable_o,
    output logic [15:0]                         drop_cnt_o
);

    localparam int LINE_W = ADDR_W - LINE_LOG;
    localparam int PG_W   = PAGE_LOG - LINE_LOG;
    localparam int OFF_W  = $clog2(NOFFSETS + 1);
    localparam int SC_W   = $clog2(SCORE_MAX + 1);
    localparam int RD_W   = $clog2(ROUND_MAX + 1);
    localparam int IX_W   = $clog2(RR_ENTRIES);
    localparam int TI_W   = (NOFFSETS > 1) ? $clog2(NOFFSETS) : 1;
    localparam int K_W    = 3;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    function automatic logic same_pg(logic [LINE_W-1:0] a, logic [LINE_W-1:0] b);
        return a[LINE_W-1:PG_W] == b[LINE_W-1:PG_W];
    endfunction

    logic trig;
    logic pf_en;

    logic [OFF_W-1:0] best_off_q;
    logic [SC_W-1:0]  best_score_q;

    assign trig  = acc_valid_i & (~acc_hit_i | acc_pf_hit_i);
    assign pf_en = best_off_q != '0;

    // ---------------- recent-requests table ----------------
    logic [RR_ENTRIES-1:0] rr_v_q;
    logic [RR_TAG-1:0]     rr_tag_q [RR_ENTRIES];

    logic [TI_W-1:0]   idx_q;
    logic [LINE_W-1:0] look_line;
    logic [IX_W-1:0]   look_ix;
    logic [RR_TAG-1:0] look_tag;
    logic              rr_hit;
    logic              ins_en;
    logic [LINE_W-1:0] ins_line;
    logic [IX_W-1:0]   ins_ix;
    logic [RR_TAG-1:0] ins_tag;

    assign look_line = acc_line_i - LINE_W'(idx_q) - LINE_W'(1);
    assign look_ix   = look_line[IX_W-1:0];
    assign look_tag  = look_line[IX_W +: RR_TAG];
    assign rr_hit    = rr_v_q[look_ix] && (rr_tag_q[look_ix] == look_tag);

    // Prefetched fills are stored as their trigger line so future offsets match.
    assign ins_en   = fill_valid_i & (~pf_en | fill_pf_i);
    assign ins_line = pf_en ? fill_line_i - LINE_W'(best_off_q) : fill_line_i;
    assign ins_ix   = ins_line[IX_W-1:0];
    assign ins_tag  = ins_line[IX_W +: RR_TAG];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_v_q <= '0;
        end else if (ins_en) begin
            rr_v_q[ins_ix] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ins_en) begin
            rr_tag_q[ins_ix] <= ins_tag;
        end
    end

    // ---------------- offset learning ----------------
    logic [SC_W-1:0] score_q [NOFFSETS];
    logic [RD_W-1:0] round_q;

    logic [SC_W-1:0] sc_cur;
    logic [SC_W-1:0] sc_new;
    logic [RD_W-1:0] rnd_new;
    logic            wrap;
    logic            phase_end;
    logic [SC_W-1:0] max_v;
    logic [TI_W-1:0] best_i;
    logic [SC_W-1:0] cand;

    always_comb begin
        sc_cur  = score_q[idx_q];
        sc_new  = sc_cur + SC_W'(rr_hit && (sc_cur != SC_W'(SCORE_MAX)));
        wrap    = idx_q == TI_W'(NOFFSETS - 1);
        rnd_new = round_q + RD_W'(wrap && (round_q != RD_W'(ROUND_MAX)));
        phase_end = trig && ((sc_new == SC_W'(SCORE_MAX)) ||
                             (wrap && (rnd_new == RD_W'(ROUND_MAX))));
        max_v  = '0;
        best_i = '0;
        cand   = '0;
        for (int i = 0; i < NOFFSETS; i++) begin
            cand = (TI_W'(i) == idx_q) ? sc_new : score_q[i];
            if (cand > max_v) begin
                max_v  = cand;
                best_i = TI_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NOFFSETS; i++) score_q[i] <= '0;
            idx_q        <= '0;
            round_q      <= '0;
            best_off_q   <= OFF_W'(1);
            best_score_q <= '0;
        end else if (phase_end) begin
            for (int i = 0; i < NOFFSETS; i++) score_q[i] <= '0;
            idx_q        <= '0;
            round_q      <= '0;
            best_score_q <= max_v;
            best_off_q   <= (max_v <= SC_W'(BAD_SCORE)) ? '0 : OFF_W'(best_i) + OFF_W'(1);
        end else if (trig) begin
            score_q[idx_q] <= sc_new;
            idx_q          <= wrap ? '0 : idx_q + TI_W'(1);
            round_q        <= rnd_new;
        end
    end

    // ---------------- issue FSM ----------------
    state_t            st_q;
    logic              pf_valid_q;
    logic [LINE_W-1:0] pf_line_q;
    logic [LINE_W-1:0] base_q;
    logic [OFF_W-1:0]  off_q;
    logic [K_W-1:0]    k_q;
    logic [15:0]       drop_q;
    logic [LINE_W-1:0] first_line;
    logic [LINE_W-1:0] next_line;

    assign first_line = acc_line_i + LINE_W'(best_off_q);
    assign next_line  = pf_line_q + LINE_W'(off_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= S_IDLE;
            pf_valid_q <= 1'b0;
            pf_line_q  <= '0;
            base_q     <= '0;
            off_q      <= '0;
            k_q        <= K_W'(1);
            drop_q     <= '0;
        end else begin
            if (trig && st_q == S_ISSUE && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
            unique case (st_q)
                S_IDLE: begin
                    if (trig && pf_en) begin
                        base_q     <= acc_line_i;
                        off_q      <= best_off_q;
                        k_q        <= K_W'(1);
                        pf_line_q  <= first_line;
                        pf_valid_q <= same_pg(first_line, acc_line_i);
                        st_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!pf_valid_q) begin
                        st_q <= S_IDLE;
                    end else if (pf_ready_i) begin
                        if (k_q == K_W'(DEGREE)) begin
                            pf_valid_q <= 1'b0;
                            st_q       <= S_IDLE;
                        end else begin
                            k_q        <= k_q + K_W'(1);
                            pf_line_q  <= next_line;
                            pf_valid_q <= same_pg(next_line, base_q);
                        end
                    end
                end
                default: st_q <= S_IDLE;
            endcase
        end
    end

    assign pf_valid_o    = pf_valid_q;
    assign pf_line_o     = pf_line_q;
    assign best_offset_o = best_off_q;
    assign best_score_o  = best_score_q;
    assign pf_enable_o   = pf_en;
    assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_bop_engine.sv
// Bench for bop_engine: directed vector table, hand sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_bop_engine;

    localparam int ADDR_W = 48;
    localparam int LINE_LOG = 6;
    localparam int LW = ADDR_W - LINE_LOG;
    localparam int PGW = 6;
    localparam int NOFF = 16;
    localparam int DEG = 2;
    localparam int RRE = 64;
    localparam int IXW = 6;
    localparam int RRT = 12;
    localparam int SMAX = 31;
    localparam int RMAX = 100;
    localparam int BAD = 1;

    typedef logic [LW-1:0] line_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        acc_valid_i = 1'b0;
    line_t       acc_line_i = '0;
    logic        acc_hit_i = 1'b0;
    logic        acc_pf_hit_i = 1'b0;
    logic        fill_valid_i = 1'b0;
    line_t       fill_line_i = '0;
    logic        fill_pf_i = 1'b0;
    logic        pf_ready_i = 1'b1;
    logic        pf_valid_o;
    line_t       pf_line_o;
    logic [4:0]  best_offset_o;
    logic [4:0]  best_score_o;
    logic        pf_enable_o;
    logic [15:0] drop_cnt_o;

    bop_engine dut (
        .clk(clk), .rst(rst),
        .acc_valid_i(acc_valid_i), .acc_line_i(acc_line_i),
        .acc_hit_i(acc_hit_i), .acc_pf_hit_i(acc_pf_hit_i),
        .fill_valid_i(fill_valid_i), .fill_line_i(fill_line_i),
        .fill_pf_i(fill_pf_i),
        .pf_valid_o(pf_valid_o), .pf_ready_i(pf_ready_i),
        .pf_line_o(pf_line_o), .best_offset_o(best_offset_o),
        .best_score_o(best_score_o), .pf_enable_o(pf_enable_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    bit    m_v [RRE];
    line_t m_l [RRE];
    int    m_sc [NOFF];
    int    m_idx, m_rnd, m_boff, m_bsc, m_drop;
    line_t m_q [$];
    bit    m_cross;
    bit    m_live = 0;

    function automatic void m_reset();
        for (int i = 0; i < RRE; i++) m_v[i] = 0;
        for (int i = 0; i < NOFF; i++) m_sc[i] = 0;
        m_idx = 0; m_rnd = 0; m_boff = 1; m_bsc = 0; m_drop = 0;
        m_q.delete();
        m_cross = 0;
    endfunction

    function automatic bit m_hit(line_t l);
        int i;
        i = int'(l[IXW-1:0]);
        return m_v[i] && (m_l[i][IXW+RRT-1:0] == l[IXW+RRT-1:0]);
    endfunction

    function automatic void m_ins(line_t l);
        int i;
        i = int'(l[IXW-1:0]);
        m_v[i] = 1;
        m_l[i] = l;
    endfunction

    function automatic bit same_pg(line_t a, line_t b);
        return (a >> PGW) == (b >> PGW);
    endfunction

    function automatic void m_check();
        chk("pf_valid", pf_valid_o, m_q.size() > 0);
        if (m_q.size() > 0) chk("pf_line", pf_line_o, m_q[0]);
        chk("best_offset", best_offset_o, m_boff);
        chk("best_score", best_score_o, m_bsc);
        chk("pf_enable", pf_enable_o, m_boff != 0);
        chk("drop_cnt", drop_cnt_o, m_drop);
    endfunction

    function automatic void m_edge();
        bit trig, busy, en, stop, pe;
        int off, mx, bi;
        line_t t;
        if (rst) begin
            m_reset();
            return;
        end
        trig = acc_valid_i && (!acc_hit_i || acc_pf_hit_i);
        off  = m_boff;
        en   = off != 0;
        busy = (m_q.size() > 0) || m_cross;
        if (m_q.size() > 0) begin
            if (pf_ready_i) m_q.delete(0);
        end else begin
            m_cross = 0;
        end
        if (trig) begin
            if (busy) begin
                if (m_drop < 65535) m_drop++;
            end else if (en) begin
                stop = 0;
                for (int k = 1; k <= DEG; k++) begin
                    if (!stop) begin
                        t = acc_line_i + line_t'(k * off);
                        if (same_pg(t, acc_line_i)) m_q.push_back(t);
                        else begin m_cross = 1; stop = 1; end
                    end
                end
            end
            pe = 0;
            if (m_hit(acc_line_i - line_t'(m_idx + 1)) && m_sc[m_idx] < SMAX)
                m_sc[m_idx]++;
            if (m_sc[m_idx] == SMAX) pe = 1;
            if (m_idx == NOFF - 1) begin
                m_idx = 0;
                if (m_rnd < RMAX) m_rnd++;
                if (m_rnd == RMAX) pe = 1;
            end else begin
                m_idx++;
            end
            if (pe) begin
                mx = 0; bi = 0;
                for (int i = 0; i < NOFF; i++)
                    if (m_sc[i] > mx) begin mx = m_sc[i]; bi = i; end
                m_bsc  = mx;
                m_boff = (mx <= BAD) ? 0 : bi + 1;
                for (int i = 0; i < NOFF; i++) m_sc[i] = 0;
                m_idx = 0; m_rnd = 0;
            end
        end
        if (fill_valid_i) begin
            if (!en) m_ins(fill_line_i);
            else if (fill_pf_i) m_ins(fill_line_i - line_t'(off));
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        if (m_live) m_check();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        acc_valid_i = 0; acc_hit_i = 0; acc_pf_hit_i = 0;
        fill_valid_i = 0; fill_pf_i = 0;
    endtask

    task automatic trig_line(line_t l);
        acc_valid_i = 1; acc_line_i = l; acc_hit_i = 0; acc_pf_hit_i = 0;
        step();
        acc_valid_i = 0;
    endtask

    task automatic do_reset();
        idle_in();
        pf_ready_i = 1;
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic chk_reset_vals(string nm);
        chk({nm, "_pf_valid"}, pf_valid_o, 0);
        chk({nm, "_pf_line"}, pf_line_o, 0);
        chk({nm, "_best_off"}, best_offset_o, 1);
        chk({nm, "_pf_en"}, pf_enable_o, 1);
        chk({nm, "_best_score"}, best_score_o, 0);
        chk({nm, "_drop"}, drop_cnt_o, 0);
    endtask

    typedef struct {
        line_t line;
        bit    v1; line_t l1;
        bit    v2; line_t l2;
        bit    v3;
    } vec_t;

    vec_t tv [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{line: 42'h100, v1: 1, l1: 42'h101, v2: 1, l2: 42'h102, v3: 0};
        tv[1] = '{line: 42'h13F, v1: 0, l1: 0, v2: 0, l2: 0, v3: 0};
        tv[2] = '{line: 42'h13E, v1: 1, l1: 42'h13F, v2: 0, l2: 0, v3: 0};
        tv[3] = '{line: {LW{1'b1}}, v1: 0, l1: 0, v2: 0, l2: 0, v3: 0};

        idle_in();
        @(posedge clk);
        #1;
        m_reset();
        m_live = 1;
        chk_reset_vals("reset");

        // directed vector table with default offset 1
        for (int i = 0; i < 4; i++) begin
            do_reset();
            trig_line(tv[i].line);
            chk("vec_v1", pf_valid_o, tv[i].v1);
            if (tv[i].v1) chk("vec_l1", pf_line_o, tv[i].l1);
            step();
            chk("vec_v2", pf_valid_o, tv[i].v2);
            if (tv[i].v2) chk("vec_l2", pf_line_o, tv[i].l2);
            step();
            chk("vec_v3", pf_valid_o, tv[i].v3);
        end

        // page-end trigger: FSM free again two cycles later
        do_reset();
        trig_line(42'h13F);
        step();
        trig_line(42'h180);
        chk("pgend_drop", drop_cnt_o, 0);
        chk("pgend_next_v", pf_valid_o, 1);
        chk("pgend_next_l", pf_line_o, 42'h181);
        step();
        step();

        // stall with a dropped second trigger
        do_reset();
        pf_ready_i = 0;
        trig_line(42'h200);
        for (int c = 1; c <= 5; c++) begin
            chk("stall_v", pf_valid_o, 1);
            chk("stall_l", pf_line_o, 42'h201);
            if (c == 3) trig_line(42'h240);
            else step();
        end
        chk("stall_drop", drop_cnt_o, 1);
        pf_ready_i = 1;
        chk("stall_rel1", pf_line_o, 42'h201);
        step();
        chk("stall_rel2_v", pf_valid_o, 1);
        chk("stall_rel2", pf_line_o, 42'h202);
        step();
        chk("stall_done", pf_valid_o, 0);

        // training toward offset 3
        do_reset();
        for (int n = 0; n < 496; n++) begin
            fill_valid_i = 1; fill_pf_i = 1;
            fill_line_i = line_t'(32'h1000 + 3 * n + 1);
            step();
            idle_in();
            step();
            trig_line(line_t'(32'h1000 + 3 * n));
        end
        step();
        step();
        chk("train_off", best_offset_o, 3);
        chk("train_score", best_score_o, 31);
        trig_line(42'h2000);
        chk("train_pf1", pf_line_o, 42'h2003);
        step();
        chk("train_pf2", pf_line_o, 42'h2006);
        step();

        // no-hit phase turns prefetching off
        do_reset();
        acc_valid_i = 1;
        for (int k = 1; k <= 1600; k++) begin
            acc_line_i = line_t'(k) << 16;
            step();
        end
        idle_in();
        chk("off_best", best_offset_o, 0);
        chk("off_en", pf_enable_o, 0);
        chk("off_score", best_score_o, 0);
        fill_valid_i = 1; fill_pf_i = 0; fill_line_i = 42'h500;
        step();
        idle_in();
        trig_line(42'h501);
        acc_valid_i = 1;
        for (int k = 1; k <= 1599; k++) begin
            acc_line_i = line_t'(k) << 16;
            step();
        end
        idle_in();
        chk("rr500_score", best_score_o, 1);
        chk("rr500_off", best_offset_o, 0);
        trig_line(42'h3000);
        for (int c = 0; c < 3; c++) begin
            chk("off_nopf", pf_valid_o, 0);
            step();
        end

        // reset during the second request
        do_reset();
        trig_line(42'h100);
        step();
        chk("rst_mid_l", pf_line_o, 42'h102);
        rst = 1;
        step();
        rst = 0;
        chk_reset_vals("rst_mid");
        step();
        chk("rst_mid_after", pf_valid_o, 0);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            acc_valid_i  = 1'($urandom % 2);
            acc_line_i   = line_t'(32'h4000 + $urandom % 200);
            acc_hit_i    = 1'($urandom % 2);
            acc_pf_hit_i = ($urandom % 4) == 0;
            fill_valid_i = 1'($urandom % 2);
            fill_line_i  = line_t'(32'h4000 + $urandom % 200);
            fill_pf_i    = 1'($urandom % 2);
            pf_ready_i   = ($urandom % 4) != 0;
            rst          = ($urandom % 700) == 0;
            step();
        end
        rst = 0;
        idle_in();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bop_engine.md
BOP_ENGINE -- requirements
Module: bop_engine

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  ADDR_W, 48, byte address width; LINE_W = ADDR_W-LINE_LOG is the line-address width
  LINE_LOG, 6, log2 line size in bytes
  PAGE_LOG, 12, log2 page size in bytes; prefetches never cross a page
  NOFFSETS, 16, candidate offsets +1..+NOFFSETS lines
  DEGREE, 2, prefetches per trigger, 1..4
  RR_ENTRIES, 64, recent-requests table entries, direct-mapped, power of 2
  RR_TAG, 12, stored tag bits per RR entry
  SCORE_MAX, 31; ROUND_MAX, 100; BAD_SCORE, 1, learning thresholds
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous reset, active-high
  acc_valid_i  in  1  upper-level access observed
  acc_line_i  in  LINE_W  access line address
  acc_hit_i  in  1  access hit
  acc_pf_hit_i  in  1  first demand hit on a prefetched line
  fill_valid_i  in  1  line fill completed
  fill_line_i  in  LINE_W  filled line address
  fill_pf_i  in  1  fill was a prefetch
  pf_valid_o  out  1  prefetch request valid
  pf_ready_i  in  1  lower level accepts request
  pf_line_o  out  LINE_W  prefetch line address
  best_offset_o  out  $clog2(NOFFSETS+1)  active offset in lines, 0 = prefetching off
  best_score_o  out  $clog2(SCORE_MAX+1)  score of the last completed phase
  pf_enable_o  out  1  best_offset_o != 0
  drop_cnt_o  out  16  saturating count of dropped triggers

Function
REQ-003 trigger = acc_valid_i & (~acc_hit_i | acc_pf_hit_i); learning and issue act only on triggers.
REQ-004 RR table: index = line[log2(RR_ENTRIES)-1:0], tag = the next RR_TAG bits; each entry holds a valid bit and a tag; lookup is combinational; a write takes effect the cycle after fill_valid_i.
REQ-005 RR insert on fill_valid_i: if fill_pf_i & pf_enable_o, insert fill_line_i - best_offset_o; if ~pf_enable_o, insert fill_line_i; otherwise no insert.
REQ-006 Same-cycle insert and lookup to one entry: the lookup sees the pre-write contents.
REQ-007 Learning: on each trigger, test candidate c = idx+1, where idx is the test index. If RR holds acc_line_i - c, score[idx]++, saturating at SCORE_MAX. idx then advances; wrap from NOFFSETS-1 to 0 increments round.
REQ-008 Phase end occurs on the trigger where any score reaches SCORE_MAX, or where round reaches ROUND_MAX on wrap. That score update is counted before the argmax.
REQ-009 At phase end: best = argmax score, lowest index on ties. best_score_o <= max score. best_offset_o <= best+1, or 0 if max score <= BAD_SCORE. All scores, idx and round clear the next cycle.
REQ-010 Line arithmetic is modulo 2^LINE_W, unsigned. Scores and round counters saturate and never wrap.
REQ-011 Issue FSM has two states, IDLE and ISSUE.
  In IDLE, a trigger with pf_enable_o=1 does the following: latch base = acc_line_i and off = the best_offset_o value before any same-cycle update; set k=1; go to ISSUE.
REQ-012 In ISSUE, target = base + k*off.
  If target is in the same page as base, pf_valid_o=1 and pf_line_o=target.
  Otherwise pf_valid_o=0 and the FSM returns to IDLE next cycle, abandoning the remaining degree.
REQ-013 Handshake completes on pf_valid_o & pf_ready_i. Then k++; if k was DEGREE, go to IDLE. pf_line_o and pf_valid_o hold stable while pf_ready_i=0.
REQ-014 A trigger while in ISSUE is not queued, including on the final-handshake cycle. It increments drop_cnt_o, saturating at 0xFFFF. Learning still processes it.
REQ-015 First prefetch latency is one cycle: pf_valid_o is asserted the cycle after the trigger. With pf_ready_i held at 1, successive requests issue on consecutive cycles.

Reset
REQ-016 When rst=1 at a clock edge, the next cycle has the following state:
  - pf_valid_o=0, pf_line_o=0
  - best_offset_o=1, pf_enable_o=1, best_score_o=0, drop_cnt_o=0
  - all scores, idx and round at 0
  - all RR valid bits clear
  - FSM in IDLE
REQ-017 Reset mid-ISSUE abandons the outstanding requests with no further pf_valid_o. rst has priority over every same-cycle event.

Verification
REQ-018 Defaults, after reset, pf_ready_i=1, trigger on line 0x100 -> pf_line_o 0x101 then 0x102 on the next two cycles, then pf_valid_o=0.
REQ-019 Trigger on line 0x13F (last line of its page) -> pf_valid_o never asserts; FSM is in IDLE two cycles later.
REQ-020 Trigger 0x200 with pf_ready_i=0 for 5 cycles, plus a second trigger on cycle 3 -> pf_line_o holds 0x201 for all 5 cycles; drop_cnt_o=1; 0x201 and 0x202 issue after ready.
REQ-021 Training run, for n=0..495:
  - stimulus: fill_pf_i=1 with fill_line_i=A+1 two cycles before each trigger A=0x1000+3n
  - response: at phase end best_offset_o=3 and best_score_o=31
  - subsequent trigger 0x2000 -> 0x2003, 0x2006.
REQ-022 1600 triggers on lines spaced 0x10000 apart with no fills -> best_offset_o=0, pf_enable_o=0, no pf_valid_o afterwards. A subsequent fill of 0x500 makes 0x500 hit the RR table.
REQ-023 Assert rst during the second request of REQ-018 -> pf_valid_o=0 the next cycle and the REQ-016 values hold.
